// File: rtl/hh_mm_timekeeper_pkg.sv
// Shared types and BCD helpers for the hours/minutes timekeeper.
// The wrap-around increment is shared by both the minutes and hours fields.
package timekeeper_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_MIN  = 2'd1,
        SET_HOUR = 2'd2
    } mode_t;

    localparam logic [7:0] MAX_MIN_BCD  = 8'h59;
    localparam logic [7:0] MAX_HOUR_BCD = 8'h23;

    // Reaching or passing the field maximum wraps to 00.
    // Any value at or above the maximum, or an invalid units digit, also
    // lands on a legal BCD result.
    function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] val,
                                                input logic [7:0] max_val);
        logic [7:0] result;
        if (val >= max_val) begin
            result = 8'h00;
        end else if (val[3:0] >= 4'd9) begin
            result = {val[7:4] + 4'd1, 4'h0};
        end else begin
            result = {val[7:4], val[3:0] + 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/hh_mm_timekeeper_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stable-level debouncer and a
// one-cycle pulse on each accepted press (debounced level falling 1 -> 0).
module button_debounce #(
    parameter int DEBOUNCE_COUNT = 500000
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    input  logic button_n_i,
    output logic press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_COUNT - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_count;
    logic             r_press;

    // The level flips only after DEBOUNCE_COUNT consecutive cycles of disagreement.
    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_count <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= button_n_i;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_count == CNT_MAX) begin
                    r_level <= r_sync2;
                    r_count <= '0;
                    r_press <= ~r_sync2;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_count <= '0;
            end
        end
    end

    assign press_o = r_press;

endmodule

// File: rtl/hh_mm_timekeeper.sv
// Minutes/hours stage fed by the seconds counter, with MODE/INC set-time
// control and a blink enable for the field currently being set.
module hh_mm_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 500000,
    parameter int BLINK_COUNT    = 12500000
) (
    input  logic       CLOCK_50_I,
    input  logic       resetn,
    input  logic       count_enable_i,
    input  logic [7:0] seconds_bcd_i,
    input  logic [3:0] PUSH_BUTTON_N_I,
    output logic [7:0] minutes_bcd_o,
    output logic [7:0] hours_bcd_o,
    output logic [1:0] mode_o,
    output logic       blink_o
);

    localparam int BLINK_W = $clog2(BLINK_COUNT + 1);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_COUNT - 1);

    logic               w_mode_press;
    logic               w_inc_press;
    logic               w_carry;
    logic               w_unused_buttons;

    mode_t              r_mode;
    logic [7:0]         r_min;
    logic [7:0]         r_hour;
    logic               r_blink;
    logic [BLINK_W-1:0] r_blink_cnt;

    mode_t              w_mode_next;
    logic [7:0]         w_min_next;
    logic [7:0]         w_hour_next;
    logic               w_blink_next;
    logic [BLINK_W-1:0] w_blink_cnt_next;

    button_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_mode_btn (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .button_n_i (PUSH_BUTTON_N_I[0]),
        .press_o    (w_mode_press)
    );

    button_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_inc_btn (
        .CLOCK_50_I (CLOCK_50_I),
        .resetn     (resetn),
        .button_n_i (PUSH_BUTTON_N_I[1]),
        .press_o    (w_inc_press)
    );

    assign w_unused_buttons = &{1'b0, PUSH_BUTTON_N_I[3:2]};
    assign w_carry = count_enable_i && (seconds_bcd_i == MAX_MIN_BCD);

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_mode      <= RUN;
            r_min       <= 8'h00;
            r_hour      <= 8'h00;
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else begin
            r_mode      <= w_mode_next;
            r_min       <= w_min_next;
            r_hour      <= w_hour_next;
            r_blink     <= w_blink_next;
            r_blink_cnt <= w_blink_cnt_next;
        end
    end

    // MODE outranks INC; in RUN a carry is applied even if MODE also fires.
    always_comb begin
        w_mode_next = r_mode;
        w_min_next  = r_min;
        w_hour_next = r_hour;
        case (r_mode)
            RUN: begin
                if (w_carry) begin
                    w_min_next = bcd_inc_wrap(r_min, MAX_MIN_BCD);
                    if (r_min == MAX_MIN_BCD) begin
                        w_hour_next = bcd_inc_wrap(r_hour, MAX_HOUR_BCD);
                    end
                end
                if (w_mode_press) begin
                    w_mode_next = SET_MIN;
                end
            end
            SET_MIN: begin
                if (w_mode_press) begin
                    w_mode_next = SET_HOUR;
                end else if (w_inc_press) begin
                    w_min_next = bcd_inc_wrap(r_min, MAX_MIN_BCD);
                end
            end
            SET_HOUR: begin
                if (w_mode_press) begin
                    w_mode_next = RUN;
                end else if (w_inc_press) begin
                    w_hour_next = bcd_inc_wrap(r_hour, MAX_HOUR_BCD);
                end
            end
            default: begin
                w_mode_next = RUN;
            end
        endcase
    end

    // Blink restarts lit whenever the mode changes and is held lit in RUN.
    always_comb begin
        w_blink_next     = r_blink;
        w_blink_cnt_next = r_blink_cnt;
        if (w_mode_next == RUN || w_mode_next != r_mode) begin
            w_blink_next     = 1'b1;
            w_blink_cnt_next = '0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            w_blink_next     = ~r_blink;
            w_blink_cnt_next = '0;
        end else begin
            w_blink_cnt_next = r_blink_cnt + BLINK_W'(1);
        end
    end

    assign minutes_bcd_o = r_min;
    assign hours_bcd_o   = r_hour;
    assign mode_o        = r_mode;
    assign blink_o       = r_blink;

endmodule
